// File: rtl/cpu6_bus_pkg.sv
// Shared CPU6 bus widths, serial-port status bit positions and UART FSM state encodings.
package cpu6_bus_pkg;
  localparam int BUS_AW = 16;
  localparam int BUS_DW = 8;

  localparam int ST_RX_READY  = 0;
  localparam int ST_TX_BUSY   = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
endpackage

// File: rtl/uart_bit_engine.sv
// 8N1 TX/RX bit engines: TX drives the start bit from the tx_load edge; RX pulses rx_valid at mid stop bit.
// No backpressure: tx_load is ignored while busy, rx_valid is a one-clock pulse that must be taken.
module uart_bit_engine
  import cpu6_bus_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tx_load,
  input  logic [BUS_DW-1:0] tx_data,
  output logic              tx_busy,
  output logic              txd,
  input  logic              rxd,
  output logic              rx_valid,
  output logic [BUS_DW-1:0] rx_byte,
  output logic              rx_frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  tx_state_e         tx_state_q;
  logic [CW-1:0]     tx_cnt_q;
  logic [2:0]        tx_bit_q;
  logic [BUS_DW-1:0] tx_shift_q;
  logic              txd_q, tx_busy_q;

  rx_state_e         rx_state_q;
  logic [1:0]        rx_sync_q;
  logic              rx_prev_q;
  logic [CW-1:0]     rx_cnt_q;
  logic [2:0]        rx_bit_q;
  logic [BUS_DW-1:0] rx_shift_q, rx_byte_q;
  logic              rx_valid_q, rx_ferr_q;
  logic              rx_s;

  assign rx_s         = rx_sync_q[1];
  assign txd          = txd_q;
  assign tx_busy      = tx_busy_q;
  assign rx_valid     = rx_valid_q;
  assign rx_byte      = rx_byte_q;
  assign rx_frame_err = rx_ferr_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: if (tx_load) begin
          tx_state_q <= TX_START;
          tx_shift_q <= tx_data;
          tx_cnt_q   <= '0;
          txd_q      <= 1'b0;
          tx_busy_q  <= 1'b1;
        end
        TX_START: if (tx_cnt_q == BIT_END) begin
          tx_cnt_q   <= '0;
          tx_bit_q   <= '0;
          txd_q      <= tx_shift_q[0];
          tx_state_q <= TX_DATA;
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        TX_DATA: if (tx_cnt_q == BIT_END) begin
          tx_cnt_q <= '0;
          if (tx_bit_q == 3'd7) begin
            txd_q      <= 1'b1;
            tx_state_q <= TX_STOP;
          end else begin
            tx_bit_q   <= tx_bit_q + 1'b1;
            txd_q      <= tx_shift_q[1];
            tx_shift_q <= {1'b0, tx_shift_q[BUS_DW-1:1]};
          end
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        TX_STOP: if (tx_cnt_q == BIT_END) begin
          tx_cnt_q   <= '0;
          tx_busy_q  <= 1'b0;
          tx_state_q <= TX_IDLE;
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // A start needs a high-to-low transition, so a low stop bit cannot retrigger a frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], rxd};
      rx_prev_q  <= rx_s;
      rx_valid_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: if (!rx_s && rx_prev_q) begin
          rx_cnt_q   <= '0;
          rx_state_q <= RX_START;
        end
        RX_START: if (rx_cnt_q == HALF_END) begin
          rx_cnt_q   <= '0;
          rx_bit_q   <= '0;
          rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
        end else rx_cnt_q <= rx_cnt_q + 1'b1;
        RX_DATA: if (rx_cnt_q == BIT_END) begin
          rx_cnt_q   <= '0;
          rx_shift_q <= {rx_s, rx_shift_q[BUS_DW-1:1]};
          rx_bit_q   <= rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
        end else rx_cnt_q <= rx_cnt_q + 1'b1;
        RX_STOP: if (rx_cnt_q == BIT_END) begin
          rx_cnt_q   <= '0;
          rx_valid_q <= 1'b1;
          rx_byte_q  <= rx_shift_q;
          rx_ferr_q  <= !rx_s;
          rx_state_q <= RX_IDLE;
        end else rx_cnt_q <= rx_cnt_q + 1'b1;
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/bus_uart_responder.sv
// CPU6 bus serial port: status/data window, read data and sel registered one clock; busy writes drop, RX overflow flags overrun.
// Define RX_FIFO_EN for a FIFO_DEPTH-entry RX FIFO instead of the single holding register.
module bus_uart_responder
  import cpu6_bus_pkg::*;
#(
  parameter logic [BUS_AW-1:0] BASE_ADDR    = 16'hF200,
  parameter int                CLKS_PER_BIT = 16,
  parameter int                FIFO_DEPTH   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [BUS_AW-1:0] address,
  input  logic              write_en,
  input  logic [BUS_DW-1:0] data_in,
  output logic [BUS_DW-1:0] data_out,
  output logic              sel,
  input  logic              rxd,
  output logic              txd
);
  logic              hit, first, rd_pop_req, pop, tx_load, tx_busy;
  logic              rx_valid, rx_frame_err, rx_ready;
  logic [BUS_DW-1:0] rx_byte, rx_head, status, data_out_d;
  logic [BUS_AW-1:0] prev_addr_q;
  logic              prev_hit_q, sel_q, sel_d;
  logic [BUS_DW-1:0] data_out_q;
  logic              frame_err_q, frame_err_d, overrun_q, overrun_d;

  // Side effects fire only on the first cycle of an access, so held strobes act once.
  assign hit        = address[BUS_AW-1:1] == BASE_ADDR[BUS_AW-1:1];
  assign first      = hit && ((address != prev_addr_q) || !prev_hit_q);
  assign rd_pop_req = first && address[0] && !write_en;
  assign tx_load    = first && address[0] && write_en && !tx_busy;
  assign data_out   = data_out_q;
  assign sel        = sel_q;

  uart_bit_engine #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_engine (
    .clock        (clock),
    .reset        (reset),
    .tx_load      (tx_load),
    .tx_data      (data_in),
    .tx_busy      (tx_busy),
    .txd          (txd),
    .rxd          (rxd),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .rx_frame_err (rx_frame_err)
  );

  always_comb begin
    status               = '0;
    status[ST_RX_READY]  = rx_ready;
    status[ST_TX_BUSY]   = tx_busy;
    status[ST_OVERRUN]   = overrun_q;
    status[ST_FRAME_ERR] = frame_err_q;
    sel_d                = hit;
    data_out_d           = hit ? (address[0] ? rx_head : status) : '0;
  end

`ifdef RX_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [BUS_DW-1:0] mem_q [FIFO_DEPTH];
  logic [BUS_DW-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic [BUS_DW-1:0] last_q, last_d;
  logic              full, push;

  assign full     = count_q == (PW+1)'(FIFO_DEPTH);
  assign rx_ready = count_q != '0;
  assign pop      = rd_pop_req && rx_ready;
  assign push     = rx_valid && (!full || pop);
  assign rx_head  = rx_ready ? mem_q[rd_ptr_q] : last_q;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    last_d      = last_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      last_d      = mem_q[rd_ptr_q];
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (push) begin
      mem_d[wr_ptr_q] = rx_byte;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rx_valid && !push) overrun_d = 1'b1;
    if (rx_valid && rx_frame_err) frame_err_d = 1'b1;
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end
`else
  logic [BUS_DW-1:0] hold_q, hold_d;
  logic              ready_q, ready_d;

  assign rx_ready = ready_q;
  assign pop      = rd_pop_req && ready_q;
  assign rx_head  = hold_q;

  // A pop and a store on the same edge: the new byte wins and no overrun is flagged.
  always_comb begin
    hold_d      = hold_q;
    ready_d     = ready_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    if (pop) begin
      ready_d     = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (rx_valid) begin
      hold_d  = rx_byte;
      ready_d = 1'b1;
      if (ready_q && !pop) overrun_d = 1'b1;
      if (rx_frame_err) frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      ready_q <= ready_d;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_addr_q <= '0;
      prev_hit_q  <= 1'b0;
      sel_q       <= 1'b0;
      data_out_q  <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      prev_addr_q <= address;
      prev_hit_q  <= hit;
      sel_q       <= sel_d;
      data_out_q  <= data_out_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end
endmodule

// File: tb/tb_bus_uart_responder.sv
// Bench for bus_uart_responder: directed and random bus/serial traffic against a queue-based reference model.
module tb_bus_uart_responder;
  localparam logic [15:0] BASE   = 16'hF200;
  localparam int          CPB    = 16;
  localparam int          DEPTH  = 4;
  localparam logic [15:0] A_STAT = BASE;
  localparam logic [15:0] A_DATA = BASE + 16'd1;
  localparam logic [15:0] A_IDLE = 16'h0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] address = A_IDLE;
  logic        write_en = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic        sel;
  logic        rxd = 1'b1;
  logic        txd;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: received bytes awaiting a read, sticky flags, last value read.
  logic [7:0] rxq[$];
  bit         m_ovr = 1'b0;
  bit         m_ferr = 1'b0;
  logic [7:0] m_last = 8'h00;

  always #5 clock = ~clock;

  bus_uart_responder #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .write_en (write_en),
    .data_in  (data_in),
    .data_out (data_out),
    .sel      (sel),
    .rxd      (rxd),
    .txd      (txd)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no end of test, required $finish");
    $fatal(1, "watchdog");
  end

  function automatic void m_reset();
    rxq.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    m_last = 8'h00;
  endfunction

  function automatic void m_store(input logic [7:0] b, input bit ferr);
`ifdef RX_FIFO_EN
    if (rxq.size() == DEPTH) m_ovr = 1'b1;
    else rxq.push_back(b);
`else
    if (rxq.size() != 0) begin
      m_ovr = 1'b1;
      rxq.delete();
    end
    rxq.push_back(b);
`endif
    if (ferr) m_ferr = 1'b1;
  endfunction

  function automatic logic [7:0] m_pop();
    if (rxq.size() != 0) begin
      m_last = rxq.pop_front();
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
    end
    return m_last;
  endfunction

  function automatic logic [7:0] m_status(input bit busy);
    return {4'b0000, m_ferr, m_ovr, busy, rxq.size() != 0};
  endfunction

  task automatic bus_access(input logic [15:0] a, input logic we, input logic [7:0] din,
                            output logic [7:0] d, output logic s);
    @(posedge clock); #1;
    address = a; write_en = we; data_in = din;
    @(posedge clock); #1;
    d = data_out; s = sel;
    address = A_IDLE; write_en = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1 rxd = fr[k];
      repeat (CPB - 1) @(posedge clock);
    end
    @(posedge clock); #1 rxd = 1'b1;
    repeat (4) @(posedge clock);
    m_store(b, !stop);
  endtask

  task automatic test_reset;
    logic [7:0] d;
    logic s;
    repeat (3) @(posedge clock); #1;
    n_cmp++;
    if ({sel, data_out, txd} !== {1'b0, 8'h00, 1'b1}) begin
      n_bad++; $display("FAIL reset_init: sel/data_out/txd=%b/%h/%b required 0/00/1", sel, data_out, txd);
    end
    reset = 1'b1;
    // Start a frame of zeros and cut it short mid-data.
    @(posedge clock); #1 address = A_DATA; write_en = 1'b1; data_in = 8'h00;
    @(posedge clock); #1 address = A_STAT; write_en = 1'b0;
    repeat (40) @(posedge clock); #1;
    n_cmp++;
    if ({txd, sel} !== 2'b01) begin
      n_bad++; $display("FAIL pre_reset_frame: txd/sel=%b/%b required 0/1", txd, sel);
    end
    reset = 1'b0; #1;
    m_reset();
    n_cmp++;
    if ({sel, data_out, txd} !== {1'b0, 8'h00, 1'b1}) begin
      n_bad++; $display("FAIL reset_mid_tx: sel/data_out/txd=%b/%h/%b required 0/00/1", sel, data_out, txd);
    end
    address = A_IDLE;
    @(posedge clock); #1 reset = 1'b1;
    bus_access(A_STAT, 1'b0, 8'h00, d, s);
    n_cmp++;
    if ({s, d} !== {1'b1, 8'h00}) begin
      n_bad++; $display("FAIL reset_status: sel/status=%b/%h required 1/00", s, d);
    end
    for (int c = 0; c < 3 * CPB; c++) begin
      @(posedge clock); #1;
      if (txd !== 1'b1) begin
        n_cmp++; n_bad++; $display("FAIL reset_txd_idle: txd=%b at cycle %0d required 1", txd, c);
        break;
      end
    end
  endtask

  // Write b with write_en held 'hold' cycles; check every bit at mid-bit and busy status mid-frame.
  task automatic test_tx(input logic [7:0] b, input int hold, input bit extra);
    logic [9:0] fr;
    logic [7:0] d;
    logic s;
    bit idle_ok;
    fr = {1'b1, b, 1'b0};
    @(posedge clock); #1 address = A_DATA; write_en = 1'b1; data_in = b;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < CPB; c++) begin
        @(posedge clock); #1;
        if (k == 0 && c == hold - 1) begin address = A_IDLE; write_en = 1'b0; end
        if (c == CPB / 2) begin
          n_cmp++;
          if (txd !== fr[k]) begin
            n_bad++; $display("FAIL tx_bit%0d byte %h: txd=%b required %b", k, b, txd, fr[k]);
          end
        end
        if (k == 3 && c == 0) address = A_STAT;
        if (k == 3 && c == 1) begin
          address = A_IDLE;
          n_cmp++;
          if ({sel, data_out} !== {1'b1, m_status(1'b1)}) begin
            n_bad++; $display("FAIL tx_busy_status: sel/status=%b/%h required 1/%h", sel, data_out, m_status(1'b1));
          end
        end
        if (extra && k == 5 && c == 0) begin address = A_DATA; write_en = 1'b1; data_in = ~b; end
        if (extra && k == 5 && c == 2) begin address = A_IDLE; write_en = 1'b0; end
      end
    end
    idle_ok = 1'b1;
    for (int c = 0; c < 2 * CPB; c++) begin
      @(posedge clock); #1;
      if (txd !== 1'b1) idle_ok = 1'b0;
    end
    n_cmp++;
    if (!idle_ok) begin
      n_bad++; $display("FAIL tx_single_frame byte %h: txd=0 after stop bit, required idle 1", b);
    end
    bus_access(A_STAT, 1'b0, 8'h00, d, s);
    n_cmp++;
    if (d !== m_status(1'b0)) begin
      n_bad++; $display("FAIL tx_done_status: status=%h required %h", d, m_status(1'b0));
    end
  endtask

  task automatic test_rx_basic;
    logic [7:0] d, e;
    logic s;
    send_rx(8'h3C, 1'b1);
    bus_access(A_STAT, 1'b0, 8'h00, d, s);
    n_cmp++;
    if (d !== m_status(1'b0)) begin
      n_bad++; $display("FAIL rx_ready_status: status=%h required %h", d, m_status(1'b0));
    end
    @(posedge clock); #1 address = A_DATA;
    e = m_pop();
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      n_cmp++;
      if (data_out !== e) begin
        n_bad++; $display("FAIL rx_held_read cycle %0d: data=%h required %h", c, data_out, e);
      end
    end
    address = A_IDLE;
    bus_access(A_STAT, 1'b0, 8'h00, d, s);
    n_cmp++;
    if (d !== m_status(1'b0)) begin
      n_bad++; $display("FAIL rx_after_read_status: status=%h required %h", d, m_status(1'b0));
    end
  endtask

  task automatic test_two_bytes;
    logic [7:0] d, e;
    logic s;
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    bus_access(A_STAT, 1'b0, 8'h00, d, s);
    n_cmp++;
    if (d !== m_status(1'b0)) begin
      n_bad++; $display("FAIL two_status: status=%h required %h", d, m_status(1'b0));
    end
    for (int i = 0; i < 2; i++) begin
      e = m_pop();
      bus_access(A_DATA, 1'b0, 8'h00, d, s);
      n_cmp++;
      if (d !== e) begin
        n_bad++; $display("FAIL two_read%0d: data=%h required %h", i, d, e);
      end
      bus_access(A_STAT, 1'b0, 8'h00, d, s);
      n_cmp++;
      if (d !== m_status(1'b0)) begin
        n_bad++; $display("FAIL two_status_after%0d: status=%h required %h", i, d, m_status(1'b0));
      end
    end
  endtask

  task automatic test_frame_err;
    logic [7:0] d, e;
    logic s;
    send_rx(8'h96, 1'b0);
    bus_access(A_STAT, 1'b0, 8'h00, d, s);
    n_cmp++;
    if (d !== m_status(1'b0)) begin
      n_bad++; $display("FAIL ferr_status: status=%h required %h", d, m_status(1'b0));
    end
    e = m_pop();
    bus_access(A_DATA, 1'b0, 8'h00, d, s);
    n_cmp++;
    if (d !== e) begin
      n_bad++; $display("FAIL ferr_data: data=%h required %h", d, e);
    end
    bus_access(A_STAT, 1'b0, 8'h00, d, s);
    n_cmp++;
    if (d !== m_status(1'b0)) begin
      n_bad++; $display("FAIL ferr_cleared: status=%h required %h", d, m_status(1'b0));
    end
  endtask

  task automatic test_glitch;
    logic [7:0] d;
    logic s;
    @(posedge clock); #1 rxd = 1'b0;
    repeat (4) @(posedge clock);
    #1 rxd = 1'b1;
    repeat (3 * CPB) @(posedge clock);
    bus_access(A_STAT, 1'b0, 8'h00, d, s);
    n_cmp++;
    if (d !== m_status(1'b0)) begin
      n_bad++; $display("FAIL glitch_status: status=%h required %h", d, m_status(1'b0));
    end
  endtask

  task automatic test_decode;
    logic [7:0] d, e;
    logic s;
    logic [15:0] miss [2];
    miss[0] = 16'hF1FF;
    miss[1] = 16'hF202;
    send_rx(8'h5A, 1'b1);
    for (int i = 0; i < 2; i++) begin
      bus_access(miss[i], 1'b0, 8'h00, d, s);
      n_cmp++;
      if ({s, d} !== 9'h000) begin
        n_bad++; $display("FAIL decode_miss %h: sel/data=%b/%h required 0/00", miss[i], s, d);
      end
    end
    bus_access(A_STAT, 1'b0, 8'h00, d, s);
    n_cmp++;
    if ({s, d} !== {1'b1, m_status(1'b0)}) begin
      n_bad++; $display("FAIL decode_hit: sel/status=%b/%h required 1/%h", s, d, m_status(1'b0));
    end
    e = m_pop();
    bus_access(A_DATA, 1'b0, 8'h00, d, s);
    n_cmp++;
    if ({s, d} !== {1'b1, e}) begin
      n_bad++; $display("FAIL decode_data: sel/data=%b/%h required 1/%h", s, d, e);
    end
  endtask

  // Hold a data read across the arrival of a new byte: only the first cycle may pop.
  task automatic test_hold_read;
    logic [7:0] d, e;
    logic s;
    send_rx(8'hC3, 1'b1);
    @(posedge clock); #1 address = A_DATA;
    e = m_pop();
    @(posedge clock); #1;
    n_cmp++;
    if (data_out !== e) begin
      n_bad++; $display("FAIL hold_first: data=%h required %h", data_out, e);
    end
    send_rx(8'h7E, 1'b1);
    n_cmp++;
    if (data_out !== 8'h7E) begin
      n_bad++; $display("FAIL hold_new_head: data=%h required 7e", data_out);
    end
    address = A_IDLE;
    bus_access(A_STAT, 1'b0, 8'h00, d, s);
    n_cmp++;
    if (d !== m_status(1'b0)) begin
      n_bad++; $display("FAIL hold_status: status=%h required %h", d, m_status(1'b0));
    end
    e = m_pop();
    bus_access(A_DATA, 1'b0, 8'h00, d, s);
    n_cmp++;
    if (d !== e) begin
      n_bad++; $display("FAIL hold_data: data=%h required %h", d, e);
    end
  endtask

  task automatic test_random_rx;
    logic [7:0] d, e;
    logic s;
    int op;
    for (int i = 0; i < 16; i++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        send_rx(8'($urandom), logic'($urandom_range(0, 3) != 0));
      end else if (op == 1) begin
        e = m_pop();
        bus_access(A_DATA, 1'b0, 8'h00, d, s);
        n_cmp++;
        if (d !== e) begin
          n_bad++; $display("FAIL rand_data step %0d: data=%h required %h", i, d, e);
        end
      end else begin
        bus_access(A_STAT, 1'b0, 8'h00, d, s);
        n_cmp++;
        if (d !== m_status(1'b0)) begin
          n_bad++; $display("FAIL rand_status step %0d: status=%h required %h", i, d, m_status(1'b0));
        end
      end
    end
    while (rxq.size() != 0) begin
      e = m_pop();
      bus_access(A_DATA, 1'b0, 8'h00, d, s);
      n_cmp++;
      if (d !== e) begin
        n_bad++; $display("FAIL rand_drain: data=%h required %h", d, e);
      end
    end
    bus_access(A_STAT, 1'b0, 8'h00, d, s);
    n_cmp++;
    if (d !== m_status(1'b0)) begin
      n_bad++; $display("FAIL rand_final_status: status=%h required %h", d, m_status(1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_tx(8'hA5, 3, 1'b1);
    test_rx_basic();
    test_two_bytes();
    test_frame_err();
    test_glitch();
    test_decode();
    test_hold_read();
    test_random_rx();
    for (int i = 0; i < 3; i++) test_tx(8'($urandom), $urandom_range(1, 5), 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
